// File: rtl/bru_ctrl.sv
// Branch resolution controller: sequences the shared BRU comparator for one
// control-transfer op, resolves outcome/target, holds redirects until acked.
module bru_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             brc_i_valid,
   output logic             brc_o_ready,
   input  logic [1:0]       brc_i_op,
   input  logic [2:0]       brc_i_funct3,
   input  logic [31:0]      brc_i_pc,
   input  logic [31:0]      brc_i_rs1,
   input  logic [31:0]      brc_i_rs2,
   input  logic [31:0]      brc_i_imm,
   input  logic             brc_i_pred_taken,
   input  logic             brc_i_kill,
   output logic [31:0]      brc_o_bru_a,
   output logic [31:0]      brc_o_bru_b,
   output logic             brc_o_bru_un,
   input  logic             brc_i_bru_eq,
   input  logic             brc_i_bru_lt,
   output logic             brc_o_redirect,
   output logic [31:0]      brc_o_redirect_pc,
   input  logic             brc_i_redirect_ack,
   output logic             brc_o_done,
   output logic             brc_o_taken,
   output logic             brc_o_illegal,
   output logic             brc_o_misalign,
   output logic [31:0]      brc_o_link_pc,
   output logic [CNT_W-1:0] brc_o_cnt_branch,
   output logic [CNT_W-1:0] brc_o_cnt_mispred
);

   typedef enum logic [1:0] {IDLE, EVAL, REDIRECT} state_t;

   state_t            state_q, state_d;
   logic [1:0]        op_q, op_d;
   logic [2:0]        f3_q, f3_d;
   logic [31:0]       pc_q, pc_d, rs1_q, rs1_d, rs2_q, rs2_d, imm_q, imm_d;
   logic              pred_q, pred_d;
   logic [31:0]       rpc_q, rpc_d;
   logic              taken_q, taken_d;
   logic [CNT_W-1:0]  cnt_br_q, cnt_br_d, cnt_mp_q, cnt_mp_d;

   logic              is_br, is_jalr, legal, br_cond, ev_taken, ev_misalign, ev_mispred;
   logic              in_eval, in_redir;
   logic [31:0]       jalr_sum, target, seq_pc, next_pc;

   always_comb begin
      is_br       = (op_q == 2'b00);
      is_jalr     = (op_q == 2'b10);
      legal       = (op_q != 2'b11) && !(is_br && f3_q[2:1] == 2'b01);
      br_cond     = (f3_q[2] ? brc_i_bru_lt : brc_i_bru_eq) ^ f3_q[0];
      ev_taken    = legal && (is_br ? br_cond : 1'b1);
      jalr_sum    = rs1_q + imm_q;
      target      = is_jalr ? {jalr_sum[31:1], 1'b0} : pc_q + imm_q;
      seq_pc      = pc_q + 32'd4;
      next_pc     = ev_taken ? target : seq_pc;
      ev_misalign = ev_taken && next_pc[1];
      // Illegal and misaligned ops never redirect; JALR always does.
      ev_mispred  = legal && !ev_misalign && (is_jalr || (ev_taken != pred_q));
      in_eval     = (state_q == EVAL);
      in_redir    = (state_q == REDIRECT);
   end

   assign brc_o_ready       = (state_q == IDLE) && !rst;
   assign brc_o_bru_a       = rs1_q;
   assign brc_o_bru_b       = rs2_q;
   assign brc_o_bru_un      = f3_q[1];
   assign brc_o_redirect    = (in_eval && ev_mispred) || in_redir;
   assign brc_o_redirect_pc = in_redir ? rpc_q : ((in_eval && ev_mispred) ? next_pc : 32'd0);
   assign brc_o_done        = !brc_i_kill &&
                              ((in_eval && (!ev_mispred || brc_i_redirect_ack)) ||
                               (in_redir && brc_i_redirect_ack));
   assign brc_o_taken       = brc_o_done && (in_redir ? taken_q : ev_taken);
   assign brc_o_illegal     = brc_o_done && in_eval && !legal;
   assign brc_o_misalign    = brc_o_done && in_eval && ev_misalign;
   assign brc_o_link_pc     = brc_o_done ? seq_pc : 32'd0;
   assign brc_o_cnt_branch  = cnt_br_q;
   assign brc_o_cnt_mispred = cnt_mp_q;

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      f3_d     = f3_q;
      pc_d     = pc_q;
      rs1_d    = rs1_q;
      rs2_d    = rs2_q;
      imm_d    = imm_q;
      pred_d   = pred_q;
      rpc_d    = rpc_q;
      taken_d  = taken_q;
      cnt_br_d = cnt_br_q;
      cnt_mp_d = cnt_mp_q;
      case (state_q)
         IDLE: begin
            if (brc_i_valid && !brc_i_kill) begin
               op_d    = brc_i_op;
               f3_d    = brc_i_funct3;
               pc_d    = brc_i_pc;
               rs1_d   = brc_i_rs1;
               rs2_d   = brc_i_rs2;
               imm_d   = brc_i_imm;
               pred_d  = brc_i_pred_taken;
               state_d = EVAL;
            end
         end
         EVAL: begin
            if (brc_i_kill || brc_o_done) begin
               state_d = IDLE;
            end else begin
               // Freeze the redirect target so it stays stable while held.
               rpc_d   = next_pc;
               taken_d = ev_taken;
               state_d = REDIRECT;
            end
         end
         REDIRECT: begin
            if (brc_i_kill || brc_i_redirect_ack) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (brc_o_done) begin
         if (in_redir || legal) cnt_br_d = cnt_br_q + CNT_W'(1);
         if (brc_o_redirect)    cnt_mp_d = cnt_mp_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         op_q     <= 2'b00;
         f3_q     <= 3'b000;
         pc_q     <= 32'd0;
         rs1_q    <= 32'd0;
         rs2_q    <= 32'd0;
         imm_q    <= 32'd0;
         pred_q   <= 1'b0;
         rpc_q    <= 32'd0;
         taken_q  <= 1'b0;
         cnt_br_q <= '0;
         cnt_mp_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         f3_q     <= f3_d;
         pc_q     <= pc_d;
         rs1_q    <= rs1_d;
         rs2_q    <= rs2_d;
         imm_q    <= imm_d;
         pred_q   <= pred_d;
         rpc_q    <= rpc_d;
         taken_q  <= taken_d;
         cnt_br_q <= cnt_br_d;
         cnt_mp_q <= cnt_mp_d;
      end
   end

endmodule

// File: tb/tb_bru_ctrl.sv
// Bench for bru_ctrl: vector table with a scoreboard of completions, plus
// hand-written kill and reset sequences.
module tb_bru_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid = 1'b0, kill = 1'b0, ack = 1'b0, pred = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [2:0]  f3 = 3'b000;
   logic [31:0] pc = 0, rs1 = 0, rs2 = 0, imm = 0;
   logic        ready, bru_un, bru_eq, bru_lt, redirect, done, taken, illegal, misalign;
   logic [31:0] bru_a, bru_b, redirect_pc, link_pc, cnt_br, cnt_mp;

   int n_cmp = 0;
   int n_bad = 0;
   int exp_br = 0;
   int exp_mp = 0;

   always #5 clk = ~clk;

   bru_ctrl #(.CNT_W(32)) dut (
      .clk(clk), .rst(rst),
      .brc_i_valid(valid), .brc_o_ready(ready),
      .brc_i_op(op), .brc_i_funct3(f3),
      .brc_i_pc(pc), .brc_i_rs1(rs1), .brc_i_rs2(rs2), .brc_i_imm(imm),
      .brc_i_pred_taken(pred), .brc_i_kill(kill),
      .brc_o_bru_a(bru_a), .brc_o_bru_b(bru_b), .brc_o_bru_un(bru_un),
      .brc_i_bru_eq(bru_eq), .brc_i_bru_lt(bru_lt),
      .brc_o_redirect(redirect), .brc_o_redirect_pc(redirect_pc),
      .brc_i_redirect_ack(ack),
      .brc_o_done(done), .brc_o_taken(taken), .brc_o_illegal(illegal),
      .brc_o_misalign(misalign), .brc_o_link_pc(link_pc),
      .brc_o_cnt_branch(cnt_br), .brc_o_cnt_mispred(cnt_mp)
   );

   // Model of the shared comparator the controller drives.
   always_comb begin
      bru_eq = (bru_a == bru_b);
      bru_lt = bru_un ? (bru_a < bru_b) : ($signed(bru_a) < $signed(bru_b));
   end

   typedef struct {
      logic [1:0]  op;
      logic [2:0]  f3;
      logic [31:0] pc, rs1, rs2, imm;
      logic        pred;
      int          dly;
      logic        e_rd;
      logic [31:0] e_rpc;
      logic        e_tk, e_ill, e_mis;
   } vec_t;

   typedef struct {
      logic        tk, ill, mis;
      logic [31:0] link;
   } exp_t;

   vec_t vecs[12];
   exp_t sb_q[$];

   function automatic vec_t mk(input logic [1:0] o, input logic [2:0] f, input logic [31:0] p,
                               input logic [31:0] a, input logic [31:0] b, input logic [31:0] i,
                               input logic pr, input int d, input logic rd, input logic [31:0] rp,
                               input logic tk, input logic il, input logic mi);
      vec_t v;
      v.op = o; v.f3 = f; v.pc = p; v.rs1 = a; v.rs2 = b; v.imm = i; v.pred = pr;
      v.dly = d; v.e_rd = rd; v.e_rpc = rp; v.e_tk = tk; v.e_ill = il; v.e_mis = mi;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] o, input logic [2:0] f, input logic [31:0] p,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] i,
                        input logic pr);
      op = o; f3 = f; pc = p; rs1 = a; rs2 = b; imm = i; pred = pr; valid = 1'b1;
   endtask

   task automatic apply(input int idx, input vec_t v);
      exp_t e, g;
      int   k;
      bit   got;
      @(negedge clk);
      drive(v.op, v.f3, v.pc, v.rs1, v.rs2, v.imm, v.pred);
      #1 chk("ready_idle", 32'(ready), 32'd1);
      e.tk = v.e_tk; e.ill = v.e_ill; e.mis = v.e_mis; e.link = v.pc + 32'd4;
      sb_q.push_back(e);
      @(negedge clk);
      valid = 1'b0;
      k = 0;
      got = 0;
      while (!got && k < 16) begin
         ack = v.e_rd && (k == v.dly);
         #1;
         chk("redirect", 32'(redirect), 32'(v.e_rd));
         if (v.e_rd) chk("redirect_pc", redirect_pc, v.e_rpc);
         if (done) begin
            got = 1;
            if (sb_q.size() == 0) begin
               chk("sb_empty", 32'd1, 32'd0);
            end else begin
               g = sb_q.pop_front();
               chk("taken", 32'(taken), 32'(g.tk));
               chk("illegal", 32'(illegal), 32'(g.ill));
               chk("misalign", 32'(misalign), 32'(g.mis));
               chk("link_pc", link_pc, g.link);
            end
            chk("done_cycle", 32'(k), v.e_rd ? 32'(v.dly) : 32'd0);
         end
         @(negedge clk);
         k++;
      end
      ack = 1'b0;
      if (!got) chk("done_timeout", 32'd0, 32'd1);
      if (!v.e_ill) exp_br++;
      if (v.e_rd) exp_mp++;
      #1;
      chk("cnt_branch", cnt_br, 32'(exp_br));
      chk("cnt_mispred", cnt_mp, 32'(exp_mp));
      $display("vec %0d op=%0d f3=%0d pc=%h done_after=%0d taken=%0b", idx, v.op, v.f3, v.pc, k - 1, v.e_tk);
   endtask

   initial begin
      vecs[0]  = mk(2'd0, 3'b000, 32'h100, 32'd5, 32'd5, 32'h20, 1'b1, 0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      vecs[1]  = mk(2'd0, 3'b100, 32'h300, 32'hFFFFFFFF, 32'd1, 32'h40, 1'b0, 0, 1'b1, 32'h340, 1'b1, 1'b0, 1'b0);
      vecs[2]  = mk(2'd0, 3'b110, 32'h300, 32'hFFFFFFFF, 32'd1, 32'h40, 1'b0, 0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      vecs[3]  = mk(2'd2, 3'b000, 32'h400, 32'h1001, 32'd0, 32'd3, 1'b1, 3, 1'b1, 32'h1004, 1'b1, 1'b0, 1'b0);
      vecs[4]  = mk(2'd0, 3'b010, 32'h500, 32'd0, 32'd0, 32'h10, 1'b0, 0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      vecs[5]  = mk(2'd1, 3'b000, 32'h200, 32'd0, 32'd0, 32'h6, 1'b1, 0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      vecs[6]  = mk(2'd0, 3'b001, 32'hFFFFFFF0, 32'd1, 32'd2, 32'h20, 1'b0, 1, 1'b1, 32'h10, 1'b1, 1'b0, 1'b0);
      vecs[7]  = mk(2'd0, 3'b101, 32'h600, 32'd3, 32'd3, 32'hFFFFFFF8, 1'b1, 0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      vecs[8]  = mk(2'd0, 3'b111, 32'h700, 32'd1, 32'hFFFFFFFF, 32'h80, 1'b1, 0, 1'b1, 32'h704, 1'b0, 1'b0, 1'b0);
      vecs[9]  = mk(2'd1, 3'b000, 32'h800, 32'd0, 32'd0, 32'h100, 1'b1, 0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      vecs[10] = mk(2'd3, 3'b000, 32'hA00, 32'd0, 32'd0, 32'd0, 1'b0, 0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      vecs[11] = mk(2'd0, 3'b001, 32'hB00, 32'd7, 32'd7, 32'h10, 1'b0, 0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_redirect", 32'(redirect), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_cnt_branch", cnt_br, 32'd0);
      rst = 1'b0;
      #1 chk("ready_after_rst", 32'(ready), 32'd1);
      $display("reset released");

      for (int i = 0; i < 12; i++) apply(i, vecs[i]);

      // Kill in REDIRECT together with ack
      @(negedge clk);
      drive(2'd2, 3'b000, 32'h900, 32'd0, 32'd0, 32'h40, 1'b0);
      @(negedge clk);
      valid = 1'b0;
      #1 chk("kr_eval_redirect_pc", redirect_pc, 32'h40);
      @(negedge clk);
      kill = 1'b1; ack = 1'b1;
      #1 chk("kr_done", 32'(done), 32'd0);
      chk("kr_held", 32'(redirect), 32'd1);
      @(negedge clk);
      kill = 1'b0; ack = 1'b0;
      #1 chk("kr_redirect_drop", 32'(redirect), 32'd0);
      chk("kr_ready", 32'(ready), 32'd1);
      chk("kr_cnt_branch", cnt_br, 32'(exp_br));
      chk("kr_cnt_mispred", cnt_mp, 32'(exp_mp));
      $display("kill+ack in REDIRECT");

      // Kill in EVAL
      @(negedge clk);
      drive(2'd0, 3'b000, 32'h100, 32'd1, 32'd1, 32'h8, 1'b1);
      @(negedge clk);
      valid = 1'b0; kill = 1'b1;
      #1 chk("ke_done", 32'(done), 32'd0);
      @(negedge clk);
      kill = 1'b0;
      #1 chk("ke_ready", 32'(ready), 32'd1);
      chk("ke_cnt_branch", cnt_br, 32'(exp_br));
      $display("kill in EVAL");

      // Kill in IDLE concurrent with valid: op must not be accepted
      @(negedge clk);
      drive(2'd1, 3'b000, 32'h100, 32'd0, 32'd0, 32'h8, 1'b0);
      kill = 1'b1;
      @(negedge clk);
      valid = 1'b0; kill = 1'b0;
      #1 chk("ki_ready", 32'(ready), 32'd1);
      chk("ki_done", 32'(done), 32'd0);
      chk("ki_redirect", 32'(redirect), 32'd0);
      $display("kill with valid in IDLE");

      // Asynchronous reset mid-REDIRECT
      @(negedge clk);
      drive(2'd0, 3'b001, 32'hFFFFFFF0, 32'd1, 32'd2, 32'h20, 1'b0);
      @(negedge clk);
      valid = 1'b0;
      @(negedge clk);
      #1 chk("rr_redirect", 32'(redirect), 32'd1);
      chk("rr_redirect_pc", redirect_pc, 32'h10);
      #1 rst = 1'b1;
      #1 chk("rr_redirect0", 32'(redirect), 32'd0);
      chk("rr_redirect_pc0", redirect_pc, 32'd0);
      chk("rr_ready0", 32'(ready), 32'd0);
      chk("rr_bru_a0", bru_a, 32'd0);
      chk("rr_bru_b0", bru_b, 32'd0);
      chk("rr_cnt_branch0", cnt_br, 32'd0);
      chk("rr_cnt_mispred0", cnt_mp, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("rr_ready1", 32'(ready), 32'd1);
      $display("async reset in REDIRECT");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
